// File: rtl/wr_dest_decoder.sv
// Multi-port registered write-enable decoder.
// Fixed-priority collision arbitration with a saturating conflict counter.
module wr_dest_decoder #(
  parameter  int DEST_W = 4,
  parameter  int PORTS  = 2,
  parameter  int CNT_W  = 8,
  localparam int NREG   = 2 ** DEST_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PORTS-1:0]        in_valid,
  input  logic [PORTS*DEST_W-1:0] in_dest,
  output logic [PORTS-1:0]        in_ready,
  input  logic                    out_ready,
  output logic [PORTS-1:0]        out_valid,
  output logic [PORTS*NREG-1:0]   enable,
  output logic [NREG-1:0]         enable_any,
  output logic [CNT_W-1:0]        conflict_cnt
);

  logic [PORTS-1:0]      wins;
  logic [PORTS-1:0]      slot_free;
  logic [PORTS-1:0]      xfer;
  logic                  collide;

  logic [PORTS*NREG-1:0] enable_q;
  logic [PORTS*NREG-1:0] enable_d;
  logic [PORTS-1:0]      out_valid_q;
  logic [PORTS-1:0]      out_valid_d;
  logic [CNT_W-1:0]      conflict_cnt_q;
  logic [CNT_W-1:0]      conflict_cnt_d;

  // Lower index beats any higher index sharing its destination.
  always_comb begin
    wins    = '0;
    collide = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      wins[p] = in_valid[p];
      for (int q = 0; q < p; q++) begin
        if (in_valid[q] && in_valid[p] &&
            in_dest[q*DEST_W +: DEST_W] ==
            in_dest[p*DEST_W +: DEST_W]) begin
          wins[p] = 1'b0;
          collide = 1'b1;
        end
      end
    end
  end

  // A slot can take a request when empty or draining this cycle.
  always_comb begin
    slot_free = ~out_valid_q | {PORTS{out_ready}};
    in_ready  = slot_free & wins;
    xfer      = in_valid & in_ready;
  end

  // Per-port next state: load, clear, or hold under back-pressure.
  always_comb begin
    enable_d    = enable_q;
    out_valid_d = out_valid_q;
    for (int p = 0; p < PORTS; p++) begin
      if (slot_free[p]) begin
        if (xfer[p]) begin
          enable_d[p*NREG +: NREG] =
            NREG'(1) << in_dest[p*DEST_W +: DEST_W];
          out_valid_d[p] = 1'b1;
        end else begin
          enable_d[p*NREG +: NREG] = '0;
          out_valid_d[p] = 1'b0;
        end
      end
    end
  end

  // Count collision cycles once each, stopping at all-ones.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (collide && (conflict_cnt_q != {CNT_W{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
  end

  // Output register stage and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q       <= '0;
      out_valid_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      enable_q       <= enable_d;
      out_valid_q    <= out_valid_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Merge the registered slices; winners never share a destination.
  always_comb begin
    enable_any = '0;
    for (int p = 0; p < PORTS; p++) begin
      enable_any = enable_any |
        (enable_q[p*NREG +: NREG] & {NREG{out_valid_q[p]}});
    end
  end

  assign enable       = enable_q;
  assign out_valid    = out_valid_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_wr_dest_decoder.sv
// Directed bench for wr_dest_decoder.
// Expected outputs queue on drive, pop after the edge.
module tb_wr_dest_decoder;

  localparam int DEST_W = 4;
  localparam int PORTS  = 2;
  localparam int CNT_W  = 2;
  localparam int NREG   = 16;

  typedef struct {
    logic [15:0] en0;
    logic [15:0] en1;
    logic [1:0]  ov;
    logic [1:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  in_valid = '0;
  logic [7:0]  in_dest = '0;
  logic [1:0]  in_ready;
  logic        out_ready = 1'b1;
  logic [1:0]  out_valid;
  logic [31:0] enable;
  logic [15:0] enable_any;
  logic [1:0]  conflict_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  wr_dest_decoder #(
    .DEST_W(DEST_W),
    .PORTS (PORTS),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_dest     (in_dest),
    .in_ready    (in_ready),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .enable      (enable),
    .enable_any  (enable_any),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".en"}, enable, 32'h0);
    chk({tag, ".any"}, {16'h0, enable_any}, 32'h0);
    chk({tag, ".ov"}, {30'h0, out_valid}, 32'h0);
    chk({tag, ".cnt"}, {30'h0, conflict_cnt}, 32'h0);
  endtask

  task automatic step(input string tag,
                      input logic [1:0] v,
                      input logic [3:0] d0,
                      input logic [3:0] d1,
                      input logic ordy,
                      input logic [1:0] rdy,
                      input logic [15:0] en0,
                      input logic [15:0] en1,
                      input logic [1:0] ov,
                      input logic [1:0] cnt);
    exp_t e;
    exp_t g;
    @(negedge clk);
    in_valid  = v;
    in_dest   = {d1, d0};
    out_ready = ordy;
    #1;
    chk({tag, ".rdy"}, {30'h0, in_ready}, {30'h0, rdy});
    e.en0 = en0;
    e.en1 = en1;
    e.ov  = ov;
    e.cnt = cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end else begin
      g = sb.pop_front();
      chk({tag, ".en0"}, {16'h0, enable[15:0]}, {16'h0, g.en0});
      chk({tag, ".en1"}, {16'h0, enable[31:16]}, {16'h0, g.en1});
      chk({tag, ".any"}, {16'h0, enable_any},
          {16'h0, g.en0 | g.en1});
      chk({tag, ".ov"}, {30'h0, out_valid}, {30'h0, g.ov});
      chk({tag, ".cnt"}, {30'h0, conflict_cnt}, {30'h0, g.cnt});
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk_zero("rst0");
    chk("rst0.rdy", {30'h0, in_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill both slots, then reset between edges
    step("pre", 2'b11, 4'h1, 4'h2, 1'b1, 2'b11,
         16'h0002, 16'h0004, 2'b11, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    step("post", 2'b01, 4'h0, 4'h0, 1'b1, 2'b01,
         16'h0001, 16'h0000, 2'b01, 2'd0);

    // Back-to-back sweep on port 0
    for (int d = 0; d < 16; d++) begin
      logic [15:0] oh;
      oh = 16'h1 << d;
      step($sformatf("sweep%0d", d), 2'b01, 4'(d), 4'h0, 1'b1,
           2'b01, oh, 16'h0000, 2'b01, 2'd0);
    end

    // Distinct destinations
    step("nocol", 2'b11, 4'h3, 4'hc, 1'b1, 2'b11,
         16'h0008, 16'h1000, 2'b11, 2'd0);

    // Same destination: port 1 loses, then goes through
    step("col", 2'b11, 4'h7, 4'h7, 1'b1, 2'b01,
         16'h0080, 16'h0000, 2'b01, 2'd1);
    step("col_retry", 2'b10, 4'h0, 4'h7, 1'b1, 2'b10,
         16'h0000, 16'h0080, 2'b10, 2'd1);

    // Back-pressure
    step("bp_load", 2'b01, 4'h5, 4'h0, 1'b1, 2'b01,
         16'h0020, 16'h0000, 2'b01, 2'd1);
    step("bp1", 2'b01, 4'h9, 4'h0, 1'b0, 2'b00,
         16'h0020, 16'h0000, 2'b01, 2'd1);
    step("bp2", 2'b01, 4'h9, 4'h0, 1'b0, 2'b00,
         16'h0020, 16'h0000, 2'b01, 2'd1);
    step("bp3", 2'b11, 4'h9, 4'h4, 1'b0, 2'b10,
         16'h0020, 16'h0010, 2'b11, 2'd1);
    step("bp_rel", 2'b01, 4'h9, 4'h0, 1'b1, 2'b01,
         16'h0200, 16'h0000, 2'b01, 2'd1);
    step("idle", 2'b00, 4'h0, 4'h0, 1'b1, 2'b00,
         16'h0000, 16'h0000, 2'b00, 2'd1);

    // Clear counter, then saturate it
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_cnt");
    @(negedge clk);
    rst_n = 1'b1;
    step("sat1", 2'b11, 4'h2, 4'h2, 1'b1, 2'b01,
         16'h0004, 16'h0000, 2'b01, 2'd1);
    step("sat2", 2'b11, 4'h2, 4'h2, 1'b1, 2'b01,
         16'h0004, 16'h0000, 2'b01, 2'd2);
    step("sat3", 2'b11, 4'h2, 4'h2, 1'b1, 2'b01,
         16'h0004, 16'h0000, 2'b01, 2'd3);
    step("sat4", 2'b11, 4'h2, 4'h2, 1'b1, 2'b01,
         16'h0004, 16'h0000, 2'b01, 2'd3);
    step("sat5", 2'b11, 4'h2, 4'h2, 1'b1, 2'b01,
         16'h0004, 16'h0000, 2'b01, 2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
